// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - fixed-latency cache line-refill responder with word load port
//
// Purpose:
//   Serves line read requests from the instruction cache. A request is
//   captured in IDLE, counted down for Latency edges, and answered with the
//   whole line in a single-cycle valid pulse. A word-granular load port fills
//   the backing store at any time, including during reset.
//
// Ports:
//   clk_i             in   1         clock
//   rstn_i            in   1         asynchronous reset, active-low
//   mem_addr_i        in   32        byte address of requested line (offset bits ignored)
//   mem_read_en_i     in   1         level request, held until valid is seen
//   mem_read_valid_o  out  1         one-cycle pulse, mem_read_data_o valid this cycle
//   mem_read_data_o   out  LineSize  line data, word k in bits [32k+31:32k]
//   load_en_i         in   1         write one word into the backing store this edge
//   load_addr_i       in   32        byte address of load word (bits [1:0] ignored)
//   load_data_i       in   32        load word

module line_mem_responder #(
  parameter int ByteOffsetBits = 4,
  parameter int MemWords       = 1024,
  parameter int Latency        = 4,
  localparam int NrWordsPerLine = (2 ** ByteOffsetBits) / 4,
  localparam int LineSize       = 32 * NrWordsPerLine
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         mem_addr_i,
  input  logic                mem_read_en_i,
  output logic                mem_read_valid_o,
  output logic [LineSize-1:0] mem_read_data_o,
  input  logic                load_en_i,
  input  logic [31:0]         load_addr_i,
  input  logic [31:0]         load_data_i
);

  localparam int AW = $clog2(MemWords);
  localparam int CW = (Latency > 1) ? $clog2(Latency) : 1;
  localparam int LW = 32 - ByteOffsetBits;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [LW-1:0]       line_addr_q, line_addr_d;
  logic                valid_q, valid_d;
  logic [LineSize-1:0] data_q, data_d;

  logic [31:0]         mem [MemWords];
  logic [LineSize-1:0] line_word;
  logic [31:0]         line_base;
  logic [AW-1:0]       load_idx;

  // Only the bit ranges selected below are meaningful; the rest of the
  // address buses are don't-care by definition.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i, load_addr_i};

  // Backing store: never reset, so a preload survives reset pulses. The
  // nonblocking write means a load at the response edge is not seen by
  // that response (read-before-write).
  assign load_idx = load_addr_i[AW+1:2];

  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem[load_idx] <= load_data_i;
    end
  end

  // Word address of the line's first word; adding k and truncating to AW
  // bits gives the modulo-MemWords wrap.
  assign line_base = {line_addr_q, {ByteOffsetBits{1'b0}}} >> 2;

  always_comb begin
    line_word = '0;
    for (int k = 0; k < NrWordsPerLine; k++) begin
      line_word[32*k +: 32] = mem[AW'(line_base + 32'(k))];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      line_addr_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      line_addr_q <= line_addr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    line_addr_d = line_addr_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read_en_i) begin
          line_addr_d = mem_addr_i[31:ByteOffsetBits];
          count_d     = CW'(Latency - 1);
          state_d     = COUNT;
        end
      end
      COUNT: begin
        // Dropping the request abandons it silently.
        if (!mem_read_en_i) begin
          state_d = IDLE;
        end else if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end else begin
          data_d  = line_word;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // One dead cycle so a still-held request cannot re-trigger
        // immediately after its own response.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_read_valid_o = valid_q;
  assign mem_read_data_o  = data_q;

endmodule
